// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the multi-cycle MIPS sequencer and the
// control decoder (CPU state encoding, opcode/funct constants, classifiers).
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        LOAD  = 3'd1,
        MEM   = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] OP_ADDIU   = 6'd9;
    localparam logic [5:0] OP_LB      = 6'd32;
    localparam logic [5:0] OP_LH      = 6'd33;
    localparam logic [5:0] OP_LWL     = 6'd34;
    localparam logic [5:0] OP_LW      = 6'd35;
    localparam logic [5:0] OP_LBU     = 6'd36;
    localparam logic [5:0] OP_LHU     = 6'd37;
    localparam logic [5:0] OP_LWR     = 6'd38;
    localparam logic [5:0] OP_SB      = 6'd40;
    localparam logic [5:0] OP_SH      = 6'd41;
    localparam logic [5:0] OP_SW      = 6'd43;

    localparam logic [5:0] FN_JR      = 6'd8;
    localparam logic [5:0] FN_JALR    = 6'd9;
    localparam logic [5:0] FN_MULT    = 6'd24;
    localparam logic [5:0] FN_MULTU   = 6'd25;
    localparam logic [5:0] FN_DIV     = 6'd26;
    localparam logic [5:0] FN_DIVU    = 6'd27;

    // Loads occupy the contiguous opcode range LB..LWR.
    function automatic logic is_load(input logic [5:0] op);
        return (op >= OP_LB) && (op <= OP_LWR);
    endfunction

    // Only SB, SH and SW are stores; SWL/SWR are not supported by this core.
    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Register-indirect jumps whose target comes from rs.
    function automatic logic is_jump_reg(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_SPECIAL) && ((fn == FN_JR) || (fn == FN_JALR));
    endfunction

    // Multiply/divide instructions that may need the HI/LO unit to settle.
    function automatic logic is_mult_div(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_SPECIAL) && (fn >= FN_MULT) && (fn <= FN_DIVU);
    endfunction

endpackage

// File: rtl/cpu_state_seq.sv
// cpu_state_seq: multi-cycle FETCH/LOAD/MEM/EXEC/HALT sequencer for the
// bus-based MIPS core. Stalls on Avalon waitrequest, latches the instruction
// and load data, strobes the PC in EXEC and halts after the delay slot of a
// jump to HALT_ADDR.
// Optional feature: define MULTDIV_STALL_EN to add the md_busy input, which
// holds EXEC of MULT/MULTU/DIV/DIVU until the multiply/divide unit is done.
module cpu_state_seq
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic [31:0] jump_target,
`ifdef MULTDIV_STALL_EN
    input  logic        md_busy,
`endif
    output logic [2:0]  state,
    output logic [31:0] instr,
    output logic [31:0] mem_data,
    output logic        pc_en,
    output logic        active
);

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_instr;
    logic [31:0] r_memData;
    logic        r_haltPend;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic        w_memOp;
    logic        w_haltJump;
    logic        w_mdStall;
    logic        w_pcEn;

    assign w_opcode   = r_instr[31:26];
    assign w_funct    = r_instr[5:0];
    assign w_memOp    = is_load(w_opcode) || is_store(w_opcode);
    assign w_haltJump = is_jump_reg(w_opcode, w_funct) && (jump_target == HALT_ADDR);

`ifdef MULTDIV_STALL_EN
    assign w_mdStall  = is_mult_div(w_opcode, w_funct) && md_busy;
`else
    assign w_mdStall  = 1'b0;
`endif

    // State register; reset lands in FETCH with the CPU running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and PC strobe; EXEC retires only when no mult/div stall is pending.
    always_comb begin
        w_nextState = r_state;
        w_pcEn      = 1'b0;
        case (r_state)
            FETCH: begin
                if (!waitrequest) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                w_nextState = MEM;
            end
            MEM: begin
                if (!w_memOp || !waitrequest) begin
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                if (!w_mdStall) begin
                    w_pcEn      = 1'b1;
                    w_nextState = r_haltPend ? HALT : FETCH;
                end
            end
            HALT: begin
                w_nextState = HALT;
            end
            default: begin
                w_nextState = FETCH;
            end
        endcase
    end

    // Instruction/load-data capture and the halt-after-delay-slot flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr    <= 32'h0;
            r_memData  <= 32'h0;
            r_haltPend <= 1'b0;
        end else begin
            if (r_state == LOAD) begin
                r_instr <= readdata;
            end
            if ((r_state == MEM) && is_load(w_opcode) && !waitrequest) begin
                r_memData <= readdata;
            end
            if (w_pcEn && w_haltJump) begin
                r_haltPend <= 1'b1;
            end
        end
    end

    // The PC block starts at RESET_VECTOR, which must be word aligned.
    a_resetVectorAligned: assert property (@(posedge clk) RESET_VECTOR[1:0] == 2'b00);

    assign state    = r_state;
    assign instr    = r_instr;
    assign mem_data = r_memData;
    assign pc_en    = w_pcEn;
    assign active   = (r_state != HALT);

endmodule

// File: tb/tb_cpu_state_seq.sv
// tb_cpu_state_seq: directed bench for cpu_state_seq. Programs are described
// per instruction (word, bus wait counts, load data, jump target); a model
// expands them into the expected per-cycle outputs. Define MULTDIV_STALL_EN
// to also exercise the md_busy stall.
module tb_cpu_state_seq;

    typedef struct packed {
        logic        wr;
        logic [31:0] rd;
        logic [31:0] jt;
        logic        md;
        logic [2:0]  st;
        logic        pc;
        logic        act;
        logic [31:0] ins;
        logic [31:0] mem;
    } cyc_t;

    typedef struct {
        logic [31:0] word;
        int          fw;
        int          mw;
        logic [31:0] ld;
        logic [31:0] jt;
        int          mdb;
    } ins_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] jump_target;
`ifdef MULTDIV_STALL_EN
    logic        md_busy;
`endif
    logic [2:0]  state;
    logic [31:0] instr;
    logic [31:0] mem_data;
    logic        pc_en;
    logic        active;

    int   total = 0;
    int   bad = 0;
    int   cycleNo = 0;
    bit   expValid = 1'b0;
    cyc_t curExp;
    cyc_t trace[$];
    ins_t prog[$];

    cpu_state_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .waitrequest(waitrequest),
        .readdata   (readdata),
        .jump_target(jump_target),
`ifdef MULTDIV_STALL_EN
        .md_busy    (md_busy),
`endif
        .state      (state),
        .instr      (instr),
        .mem_data   (mem_data),
        .pc_en      (pc_en),
        .active     (active)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    function automatic ins_t mk(logic [31:0] w, int fw, int mw, logic [31:0] ld,
                                logic [31:0] jt, int mdb);
        ins_t r;
        r.word = w; r.fw = fw; r.mw = mw; r.ld = ld; r.jt = jt; r.mdb = mdb;
        return r;
    endfunction

    task automatic cmpField(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d: got %h want %h", name, cycleNo, got, want);
        end
    endtask

    task automatic pushCyc(logic wr, logic [31:0] rd, logic [31:0] jt, logic md,
                           logic [2:0] st, logic pc, logic act,
                           logic [31:0] ins, logic [31:0] mem);
        cyc_t c;
        c.wr = wr; c.rd = rd; c.jt = jt; c.md = md;
        c.st = st; c.pc = pc; c.act = act; c.ins = ins; c.mem = mem;
        trace.push_back(c);
    endtask

    // Expand the instruction list into per-cycle stimulus and expected outputs.
    task automatic buildTrace(int haltCycles);
        logic [31:0] ins = 32'h0;
        logic [31:0] mem = 32'h0;
        bit pend = 1'b0;
        bit halted = 1'b0;
        logic [5:0] op;
        logic [5:0] fn;
        bit isLd, isSt, isMd;
        trace.delete();
        for (int i = 0; i < prog.size() && !halted; i++) begin
            op   = prog[i].word[31:26];
            fn   = prog[i].word[5:0];
            isLd = (op >= 6'd32) && (op <= 6'd38);
            isSt = (op == 6'd40) || (op == 6'd41) || (op == 6'd43);
            isMd = (op == 6'd0) && (fn >= 6'd24) && (fn <= 6'd27);
            for (int k = 0; k <= prog[i].fw; k++)
                pushCyc(k < prog[i].fw, 32'hF000_0000 + k, 32'h0, 1'b1, 3'd0, 1'b0, 1'b1, ins, mem);
            pushCyc(1'b1, prog[i].word, 32'h0, 1'b1, 3'd1, 1'b0, 1'b1, ins, mem);
            ins = prog[i].word;
            if (isLd || isSt) begin
                for (int k = 0; k <= prog[i].mw; k++)
                    pushCyc(k < prog[i].mw,
                            (k < prog[i].mw) ? 32'hBAD0_0000 + k : (isLd ? prog[i].ld : 32'h5555_AAAA),
                            32'h0, 1'b1, 3'd2, 1'b0, 1'b1, ins, mem);
                if (isLd) mem = prog[i].ld;
            end else begin
                pushCyc(1'b1, 32'hBAD0_00FF, 32'h0, 1'b1, 3'd2, 1'b0, 1'b1, ins, mem);
            end
`ifdef MULTDIV_STALL_EN
            if (isMd)
                for (int k = 0; k < prog[i].mdb; k++)
                    pushCyc(1'b0, 32'h0, prog[i].jt, 1'b1, 3'd3, 1'b0, 1'b1, ins, mem);
`endif
            pushCyc(1'b1, 32'h0, prog[i].jt, !isMd, 3'd3, 1'b1, 1'b1, ins, mem);
            if (pend)
                halted = 1'b1;
            else if ((op == 6'd0) && ((fn == 6'd8) || (fn == 6'd9)) && (prog[i].jt == 32'h0))
                pend = 1'b1;
            if (halted)
                for (int k = 0; k < haltCycles; k++)
                    pushCyc(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1, 3'd4, 1'b0, 1'b0, ins, mem);
        end
    endtask

    task automatic applyStimulus(cyc_t c);
        waitrequest = c.wr;
        readdata    = c.rd;
        jump_target = c.jt;
`ifdef MULTDIV_STALL_EN
        md_busy     = c.md;
`endif
        curExp      = c;
        expValid    = 1'b1;
    endtask

    task automatic checkOutput();
        cmpField("state",    {29'h0, state},   {29'h0, curExp.st});
        cmpField("pc_en",    {31'h0, pc_en},   {31'h0, curExp.pc});
        cmpField("active",   {31'h0, active},  {31'h0, curExp.act});
        cmpField("instr",    instr,            curExp.ins);
        cmpField("mem_data", mem_data,         curExp.mem);
    endtask

    // Single compare process: checks the DUT mid-cycle against the model.
    always @(negedge clk) begin
        if (expValid) checkOutput();
    end

    task automatic doReset();
        expValid = 1'b0;
        reset_n  = 1'b0;
        #1;
        cmpField("rst_state",    {29'h0, state},  32'd0);
        cmpField("rst_instr",    instr,           32'h0);
        cmpField("rst_mem_data", mem_data,        32'h0);
        cmpField("rst_pc_en",    {31'h0, pc_en},  32'd0);
        cmpField("rst_active",   {31'h0, active}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic runProgram(int maxCycles);
        for (int c = 0; c < maxCycles && c < trace.size(); c++) begin
            applyStimulus(trace[c]);
            @(posedge clk);
            #1;
            cycleNo++;
        end
        expValid = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        waitrequest = 1'b1;
        readdata    = 32'h0;
        jump_target = 32'h0;
`ifdef MULTDIV_STALL_EN
        md_busy     = 1'b0;
`endif

        // Hand-computed pins on the model itself.
        prog.delete(); prog.push_back(mk(32'h2408_0005, 0, 0, 0, 0, 0)); buildTrace(0);
        cmpField("pin_addiu_len", trace.size(), 32'd4);
        cmpField("pin_addiu_st1", {29'h0, trace[1].st}, 32'd1);
        cmpField("pin_addiu_pc3", {31'h0, trace[3].pc}, 32'd1);
        cmpField("pin_addiu_pc2", {31'h0, trace[2].pc}, 32'd0);
        prog.delete(); prog.push_back(mk(32'h2408_0005, 3, 0, 0, 0, 0)); buildTrace(0);
        cmpField("pin_fwait_len", trace.size(), 32'd7);
        cmpField("pin_fwait_st4", {29'h0, trace[4].st}, 32'd1);
        prog.delete(); prog.push_back(mk(32'h8D09_0000, 0, 2, 32'hDEAD_BEEF, 0, 0)); buildTrace(0);
        cmpField("pin_lw_len", trace.size(), 32'd6);
        cmpField("pin_lw_mem5", trace[5].mem, 32'hDEAD_BEEF);
        cmpField("pin_lw_mem4", trace[4].mem, 32'h0);
        prog.delete(); prog.push_back(mk(32'h03E0_0008, 0, 0, 0, 0, 0));
        prog.push_back(mk(32'h0000_0000, 0, 0, 0, 0, 0)); buildTrace(20);
        cmpField("pin_halt_len", trace.size(), 32'd28);
        cmpField("pin_halt_act", {31'h0, trace[27].act}, 32'd0);

        // Main program: ALU, stalls, loads/stores, opcode boundaries, halt.
        doReset();
        prog.delete();
        prog.push_back(mk(32'h2408_0005, 0, 0, 0, 0, 0));
        prog.push_back(mk(32'h2409_0007, 3, 0, 0, 0, 0));
        prog.push_back(mk(32'h8D09_0000, 0, 2, 32'hDEAD_BEEF, 0, 0));
        prog.push_back(mk(32'hAD09_0000, 0, 0, 0, 0, 0));
        prog.push_back(mk(32'hA509_0002, 0, 1, 0, 0, 0));
        prog.push_back(mk(32'h9D09_0000, 1, 0, 0, 0, 0));
        prog.push_back(mk(32'hA909_0000, 0, 0, 0, 0, 0));
        prog.push_back(mk(32'h8109_0004, 0, 0, 32'h0000_00A5, 0, 0));
        prog.push_back(mk(32'h9509_0006, 0, 3, 32'hCAFE_F00D, 0, 0));
        prog.push_back(mk(32'h03E0_0008, 0, 0, 0, 32'h0040_0000, 0));
        prog.push_back(mk(32'h0100_F809, 2, 0, 0, 32'h0000_0000, 0));
        prog.push_back(mk(32'h0000_0000, 0, 0, 0, 0, 0));
        prog.push_back(mk(32'h2408_0001, 0, 0, 0, 0, 0));
        buildTrace(20);
        runProgram(trace.size());

        // Reset asserted in the middle of a MEM stall.
        doReset();
        prog.delete();
        prog.push_back(mk(32'h8D09_0000, 0, 0, 32'h1234_5678, 0, 0));
        prog.push_back(mk(32'h8D0A_0000, 0, 30, 32'h7777_7777, 0, 0));
        buildTrace(0);
        runProgram(10);
        cmpField("pre_rst_state", {29'h0, state}, 32'd2);
        cmpField("pre_rst_mem",   mem_data,       32'h1234_5678);
        doReset();

        // Jump-to-zero in the delay slot of a jump-to-zero.
        prog.delete();
        prog.push_back(mk(32'h03E0_0008, 0, 0, 0, 32'h0, 0));
        prog.push_back(mk(32'h03E0_0008, 1, 0, 0, 32'h0, 0));
        prog.push_back(mk(32'h2408_0002, 0, 0, 0, 0, 0));
        buildTrace(20);
        runProgram(trace.size());

`ifdef MULTDIV_STALL_EN
        // Multiply/divide stall in EXEC.
        doReset();
        prog.delete();
        prog.push_back(mk(32'h0109_001A, 0, 0, 0, 0, 5));
        prog.push_back(mk(32'h0109_0019, 0, 0, 0, 0, 0));
        prog.push_back(mk(32'h2408_0003, 0, 0, 0, 0, 0));
        buildTrace(0);
        runProgram(trace.size());
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
